// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: multiply, multiply-accumulate and divide with a
// configurable Busy latency, plus mthi/mtlo. Define MD_CANCEL_EN to add the Cancel port.
module md_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [2:0]       MDOperator,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HLRegWrite,
    input  logic             HLSelect,
`ifdef MD_CANCEL_EN
    input  logic             Cancel,
`endif
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        OP_MULTU = 3'd0, OP_MULT  = 3'd1, OP_DIVU  = 3'd2, OP_DIV   = 3'd3,
        OP_MADD  = 3'd4, OP_MADDU = 3'd5, OP_MSUB  = 3'd6, OP_MSUBU = 3'd7
    } md_op_t;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    md_op_t           op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt;
    logic             cancel_hit;

`ifdef MD_CANCEL_EN
    assign cancel_hit = Cancel;
`else
    assign cancel_hit = 1'b0;
`endif

    // Write-back value, evaluated from the latched operands and the current HI/LO.
    logic               sgn_mul, sgn_div, neg_a, neg_b, is_div, do_write;
    logic [2*WIDTH-1:0] sa, sb, prod, acc, wb;
    logic [WIDTH-1:0]   mag_a, mag_b, divisor, q_mag, r_mag, quo, rem;

    always_comb begin
        sgn_mul = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        sa      = {{WIDTH{sgn_mul & a_q[WIDTH-1]}}, a_q};
        sb      = {{WIDTH{sgn_mul & b_q[WIDTH-1]}}, b_q};
        prod    = sa * sb;
        acc     = {HI, LO};

        // Sign-magnitude divide: MIN / -1 falls out as LO = MIN, HI = 0.
        is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU);
        sgn_div = (op_q == OP_DIV);
        neg_a   = sgn_div & a_q[WIDTH-1];
        neg_b   = sgn_div & b_q[WIDTH-1];
        mag_a   = neg_a ? -a_q : a_q;
        mag_b   = neg_b ? -b_q : b_q;
        divisor = (b_q == '0) ? WIDTH'(1) : mag_b;
        q_mag   = mag_a / divisor;
        r_mag   = mag_a % divisor;
        quo     = (neg_a ^ neg_b) ? -q_mag : q_mag;
        rem     = neg_a ? -r_mag : r_mag;

        do_write = !(is_div && (b_q == '0));
        case (op_q)
            OP_MULT, OP_MULTU: wb = prod;
            OP_MADD, OP_MADDU: wb = acc + prod;
            OP_MSUB, OP_MSUBU: wb = acc - prod;
            default:           wb = {rem, quo};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= OP_MULTU;
            a_q   <= '0;
            b_q   <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= RUN;
                        Busy  <= 1'b1;
                        op_q  <= md_op_t'(MDOperator);
                        a_q   <= A;
                        b_q   <= B;
                        cnt   <= (MDOperator == OP_DIVU || MDOperator == OP_DIV)
                                 ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                    end else if (HLRegWrite) begin
                        if (HLSelect) HI <= A;
                        else          LO <= A;
                    end
                end
                RUN: begin
                    if (cancel_hit) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == CW'(1)) begin
                        if (do_write) begin
                            HI <= wb[2*WIDTH-1:WIDTH];
                            LO <= wb[WIDTH-1:0];
                        end
                        state <= IDLE;
                        Busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (default parameters); Cancel cases
// are compiled in when MD_CANCEL_EN is defined.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Start;
    logic [2:0]  MDOperator;
    logic [31:0] A, B;
    logic        HLRegWrite;
    logic        HLSelect;
`ifdef MD_CANCEL_EN
    logic        Cancel;
`endif
    logic        Busy;
    logic [31:0] HI, LO;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    md_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Start      (Start),
        .MDOperator (MDOperator),
        .A          (A),
        .B          (B),
        .HLRegWrite (HLRegWrite),
        .HLSelect   (HLSelect),
`ifdef MD_CANCEL_EN
        .Cancel     (Cancel),
`endif
        .Busy       (Busy),
        .HI         (HI),
        .LO         (LO)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive Start for the edge T0; returns at the negedge in busy cycle 1.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; MDOperator = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0;
    endtask

    // Count busy cycles from the current negedge until Busy drops (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (Busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int c;
        start_op(op, a, b);
        wait_done(c);
        check({tag, ".busy"}, 32'(c), 32'(exp_cyc));
        check({tag, ".hi"}, HI, exp_hi);
        check({tag, ".lo"}, LO, exp_lo);
    endtask

    task automatic hl_write(input logic sel, input logic [31:0] data);
        HLRegWrite = 1'b1; HLSelect = sel; A = data;
        @(negedge clk);
        HLRegWrite = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        reset_n = 1'b0; Start = 1'b0; MDOperator = 3'd0; A = '0; B = '0;
        HLRegWrite = 1'b0; HLSelect = 1'b0;
`ifdef MD_CANCEL_EN
        Cancel = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(Busy), 32'd0);
        check("rst.hi", HI, 32'h0);
        check("rst.lo", LO, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Multiplies, back-to-back starts at T0+N+1.
        run_op("mult",  3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);

        // Divides.
        run_op("div",     3'd3, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0",   3'd2, 32'h1234_5678, 32'd0,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_neg", 3'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_min", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

        // mthi/mtlo then accumulate chain.
        hl_write(1'b1, 32'h0);
        hl_write(1'b0, 32'hFFFF_FFFF);
        check("mthi", HI, 32'h0);
        check("mtlo", LO, 32'hFFFF_FFFF);
        run_op("madd",  3'd4, 32'd1, 32'd1, 5, 32'h0000_0001, 32'h0000_0000);
        run_op("msub",  3'd6, 32'd1, 32'd1, 5, 32'h0000_0000, 32'hFFFF_FFFF);
        run_op("msubu", 3'd7, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("maddu", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFD, 32'h0000_0002);

        // Start and mtlo while busy are both ignored.
        start_op(3'd1, 32'd3, 32'd4);
        @(negedge clk);
        Start = 1'b1; MDOperator = 3'd0; HLRegWrite = 1'b1; HLSelect = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'd5;
        @(negedge clk);
        Start = 1'b0; HLRegWrite = 1'b0;
        check("coll.lo_mid", LO, 32'h0000_0002);
        wait_done(c);
        check("coll.busy", 32'(c + 2), 32'd5);
        check("coll.hi", HI, 32'h0);
        check("coll.lo", LO, 32'h0000_000C);
        @(negedge clk);
        check("coll.no_relaunch", 32'(Busy), 32'd0);

        // Start and mthi in the same cycle: Start wins.
        hl_write(1'b1, 32'h0000_1234);
        Start = 1'b1; MDOperator = 3'd0; A = 32'd2; B = 32'd3;
        HLRegWrite = 1'b1; HLSelect = 1'b1;
        @(negedge clk);
        Start = 1'b0; HLRegWrite = 1'b0;
        check("st_mthi.busy", 32'(Busy), 32'd1);
        check("st_mthi.hi_mid", HI, 32'h0000_1234);
        wait_done(c);
        check("st_mthi.hi", HI, 32'h0);
        check("st_mthi.lo", LO, 32'h0000_0006);

        // Reset in cycle 3 of a div.
        start_op(3'd3, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid.busy", 32'(Busy), 32'd0);
        check("rst_mid.hi", HI, 32'h0);
        check("rst_mid.lo", LO, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_mid.hi_late", HI, 32'h0);
        check("rst_mid.lo_late", LO, 32'h0);
        check("rst_mid.busy_late", 32'(Busy), 32'd0);

`ifdef MD_CANCEL_EN
        hl_write(1'b1, 32'h0000_AAAA);
        hl_write(1'b0, 32'h0000_5555);
        start_op(3'd1, 32'd3, 32'd3);
        repeat (3) @(negedge clk);
        Cancel = 1'b1;
        @(negedge clk);
        Cancel = 1'b0;
        check("cancel4.busy", 32'(Busy), 32'd0);
        repeat (8) @(negedge clk);
        check("cancel4.hi", HI, 32'h0000_AAAA);
        check("cancel4.lo", LO, 32'h0000_5555);

        start_op(3'd1, 32'd3, 32'd3);
        repeat (4) @(negedge clk);
        Cancel = 1'b1;
        @(negedge clk);
        Cancel = 1'b0;
        check("cancel_end.busy", 32'(Busy), 32'd0);
        check("cancel_end.lo", LO, 32'h0000_5555);

        Cancel = 1'b1;
        start_op(3'd1, 32'd3, 32'd3);
        Cancel = 1'b0;
        check("cancel_idle.busy", 32'(Busy), 32'd1);
        wait_done(c);
        check("cancel_idle.cyc", 32'(c), 32'd5);
        check("cancel_idle.lo", LO, 32'h0000_0009);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
